// File: rtl/cpu_pkg.sv
// Shared definitions for the core's fetch/PC control path.
//   - NPC op encodings, which must match the control unit.
//   - Sequencer state type used by pc_seq_ctrl.
package cpu_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target selection.
//   pc        in  32  current PC, used for the +4 fallback
//   npc_in    in  32  next-address result from the NPC unit
//   npc_op    in  3   NPC op of the executing instruction
//   target    out 32  selected target (JALR bit0 already cleared)
//   misalign  out 1   target[1:0] != 0
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] npc_in,
    input  logic [2:0]  npc_op,
    output logic [31:0] target,
    output logic        misalign
);

    always_comb begin
        target = pc + 32'd4;
        case (npc_op)
            NPC_PLUS4,
            NPC_BRANCH,
            NPC_JAL:    target = npc_in;
            NPC_JALR:   target = {npc_in[31:1], 1'b0};
            // Unknown ops fall back to sequential flow; npc_in is ignored.
            default:    target = pc + 32'd4;
        endcase
        misalign = |target[1:0];
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC register and fetch/execute sequencer for the single-cycle core.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned target -> TRAP_VEC + trap pulse).
//   clk          in   1      core clock, rising edge
//   rst          in   1      synchronous active-high reset
//   npc_in       in   32     next address from the NPC unit
//   npc_op       in   3      NPC op of the executing instruction
//   commit       in   1      retire pulse for the current instruction
//   halt_req     in   1      stop after the current instruction retires
//   imem_req     out  1      instruction fetch request
//   imem_addr    out  32     fetch address (= pc)
//   imem_ack     in   1      fetch data valid
//   imem_rdata   in   32     fetched instruction
//   pc           out  32     current PC
//   instr        out  32     latched instruction
//   instr_valid  out  1      instr may be executed
//   halted       out  1      controller is halted
//   trap         out  1      one-cycle misaligned-target pulse
//   instret      out  CNT_W  retired-instruction count
module pc_seq_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc_in,
    input  logic [2:0]       npc_op,
    input  logic             commit,
    input  logic             halt_req,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    pc_state_t        state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             instr_valid_q, instr_valid_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [31:0]      target;
    logic             misalign;
    logic [31:0]      commit_pc;

    pc_target_calc u_target (
        .pc       (pc_q),
        .npc_in   (npc_in),
        .npc_op   (npc_op),
        .target   (target),
        .misalign (misalign)
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign commit_pc = misalign ? TRAP_VEC : target;
`else
    // Low bits are forced aligned; the trap vector and detector are not used.
    logic unused_cfg;
    assign unused_cfg = ^{TRAP_VEC, misalign};
    assign commit_pc  = {target[31:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VEC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            trap_q        <= 1'b0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            trap_q        <= trap_d;
            instret_q     <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        trap_d        = 1'b0;
        instret_d     = instret_q;
        imem_req      = 1'b0;
        halted        = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    instr_valid_d = 1'b0;
                    instret_d     = instret_q + CNT_W'(1);
                    pc_d          = commit_pc;
`ifdef PC_MISALIGN_TRAP_EN
                    trap_d        = misalign;
`endif
                    state_d       = halt_req ? HALT : FETCH;
                end
            end
            HALT: begin
                halted        = 1'b1;
                instr_valid_d = 1'b0;
                if (!halt_req) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign trap        = trap_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl (default parameters).
module tb_pc_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] npc_in;
    logic [2:0]  npc_op;
    logic        commit;
    logic        halt_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        trap;
    logic [31:0] instret;

    int unsigned n_chk;
    int unsigned n_bad;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] EXP_TRAP = 32'd1;
`else
    localparam logic [31:0] EXP_TRAP = 32'd0;
`endif

    pc_seq_ctrl #(
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc_in      (npc_in),
        .npc_op      (npc_op),
        .commit      (commit),
        .halt_req    (halt_req),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted),
        .trap        (trap),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From FETCH: zero-wait ack, ending in EXEC.
    task automatic fetch_now(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic do_commit(input logic [2:0] op, input logic [31:0] npc, input logic hreq);
        npc_op   = op;
        npc_in   = npc;
        commit   = 1'b1;
        halt_req = hreq;
        step();
        commit   = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        npc_in     = '0;
        npc_op     = '0;
        commit     = 1'b0;
        halt_req   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;

        @(negedge clk);
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_instret", instret, 32'd0);

        // BOOT -> FETCH
        rst = 1'b0;
        step();
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, 32'h0);

        fetch_now(32'hDEAD_0001);
        chk("f0_valid", {31'd0, instr_valid}, 32'd1);
        chk("f0_instr", instr, 32'hDEAD_0001);
        chk("f0_req", {31'd0, imem_req}, 32'd0);

        // Ack while in EXEC must not disturb the latched instruction.
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        imem_ack   = 1'b0;
        chk("exec_ack_ign", instr, 32'hDEAD_0001);

        do_commit(3'b000, 32'h0000_0004, 1'b0);
        chk("p4_pc", pc, 32'h4);
        chk("p4_instret", instret, 32'd1);
        chk("p4_valid", {31'd0, instr_valid}, 32'd0);
        chk("p4_req", {31'd0, imem_req}, 32'd1);
        chk("p4_addr", imem_addr, 32'h4);

        // Delayed ack; commits during the wait are ignored.
        for (int i = 0; i < 5; i++) begin
            commit = (i % 2) == 0;
            step();
            chk("wait_addr", imem_addr, 32'h4);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_instret", instret, 32'd1);
        end
        commit = 1'b0;
        fetch_now(32'h0000_1111);
        chk("f1_instr", instr, 32'h0000_1111);

        // JALR clears bit0
        do_commit(3'b100, 32'h0000_0025, 1'b0);
        chk("jalr_pc", pc, 32'h24);
        chk("jalr_trap", {31'd0, trap}, 32'd0);
        chk("jalr_instret", instret, 32'd2);

        // Misaligned branch target: 0x100 either via trap vector or forced alignment.
        fetch_now(32'h0000_2222);
        do_commit(3'b001, 32'h0000_0102, 1'b0);
        chk("mis_pc", pc, 32'h100);
        chk("mis_trap", {31'd0, trap}, EXP_TRAP);
        chk("mis_instret", instret, 32'd3);
        step();
        chk("mis_trap_end", {31'd0, trap}, 32'd0);

        // Unlisted op falls back to pc+4, ignoring npc_in.
        fetch_now(32'h0000_3333);
        do_commit(3'b111, 32'hFFFF_0000, 1'b0);
        chk("bad_op_pc", pc, 32'h104);
        chk("bad_op_instret", instret, 32'd4);

        // Halt after JAL retire.
        fetch_now(32'h0000_4444);
        do_commit(3'b010, 32'h0000_0200, 1'b1);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_req_lo", {31'd0, imem_req}, 32'd0);
        chk("halt_pc", pc, 32'h200);
        chk("halt_instret", instret, 32'd5);
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("halt_hold", {31'd0, halted}, 32'd1);
        chk("halt_commit_ign", instret, 32'd5);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        halt_req = 1'b0;
        step();
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h200);

        // Reset mid-FETCH with a simultaneous ack.
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        rst        = 1'b0;
        imem_ack   = 1'b0;
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mrst_instr", instr, 32'h0);
        chk("mrst_instret", instret, 32'd0);
        step();
        chk("mrst_refetch", {31'd0, imem_req}, 32'd1);
        chk("mrst_addr", imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
